hs_intf_arb_mux: RTL and testbench

- N-channel merge block. Accepts an array of valid/ready handshake interfaces and buffers each channel in its own FIFO.
- Channels are merged onto one output interface by round-robin arbitration, and every output word is tagged with its source channel number.
- Generalises the per-bit source/sink interface-array connection to parametrised data width, channel count and buffer depth, with flow control and fair arbitration.
- Sits between N producer blocks and a single shared consumer.
- Deliverables: interface hs_if #(W) with fields valid, ready, data[W-1:0]; modport source (output valid, data; input ready); modport sink (input valid, data; output ready).

---
 rtl/hs_intf_arb_mux_if.sv | 11 +
 rtl/hs_intf_arb_mux.sv | 159 +++++++++++++++
 tb/tb_hs_intf_arb_mux.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_intf_arb_mux_if.sv
// Valid/ready handshake bundle; source drives valid/data, sink drives ready.
interface hs_if #(
  parameter int W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport source (output valid, data, input ready);
  modport sink   (input valid, data, output ready);
endinterface

// File: rtl/hs_intf_arb_mux.sv
// N-channel FIFO-buffered round-robin merge with source-channel tag.
// One-cycle push-to-output latency; input ready comes only from registered FIFO state.

module hs_arb_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  // push_rdy is registered, so a pop on the edge where the FIFO is full
  // cannot open the door for a push on that same edge.
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = pop & ~empty;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign head_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      push_rdy <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      push_rdy <= (count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_dat;
  end
endmodule

module hs_intf_arb_mux #(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  hs_if.sink            in_if [N-1:0],
  hs_if.source          out_if,
  output logic [CW-1:0] out_chan,
  output logic [N-1:0]  fifo_full
);
  logic [N-1:0]  nonempty;
  logic [N-1:0]  pop_vec;
  logic [W-1:0]  head [N];
  logic [CW-1:0] rr_q;
  logic [CW-1:0] gnt;
  logic          any;
  logic          load_en;
  logic          take;
  int            idx;

  logic          out_vld_q;
  logic [W-1:0]  out_dat_q;
  logic [CW-1:0] out_chan_q;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic empty_i;

    hs_arb_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (in_if[i].valid),
      .push_dat (in_if[i].data),
      .push_rdy (in_if[i].ready),
      .pop      (pop_vec[i]),
      .head_dat (head[i]),
      .empty    (empty_i),
      .full     (fifo_full[i])
    );

    assign nonempty[i] = ~empty_i;
  end

  // First non-empty channel at or after the RR pointer, wrapping at N.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N)
        idx = idx - N;
      if (!any && nonempty[idx]) begin
        any = 1'b1;
        gnt = idx[CW-1:0];
      end
    end
  end

  assign load_en = ~out_vld_q | out_if.ready;
  assign take    = load_en & any;

  always_comb begin
    pop_vec = '0;
    if (take)
      pop_vec[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_chan_q <= '0;
      rr_q       <= '0;
    end else if (load_en) begin
      out_vld_q <= any;
      if (any) begin
        out_dat_q  <= head[gnt];
        out_chan_q <= gnt;
        rr_q       <= (gnt == CW'(N - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  assign out_if.valid = out_vld_q;
  assign out_if.data  = out_dat_q;
  assign out_chan     = out_chan_q;
endmodule

// File: tb/tb_hs_intf_arb_mux.sv
// Directed bench for hs_intf_arb_mux (N=4, W=8, DEPTH=4).
module tb_hs_intf_arb_mux;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_vld = '0;
  logic [W-1:0] in_dat [N];
  logic [N-1:0] in_rdy;
  logic         out_rdy = 1'b0;
  logic [1:0]   out_chan;
  logic [N-1:0] fifo_full;

  int n_vec = 0;
  int n_err = 0;

  hs_if #(.W(W)) in_if [N-1:0] ();
  hs_if #(.W(W)) out_if ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign in_if[g].valid = in_vld[g];
    assign in_if[g].data  = in_dat[g];
    assign in_rdy[g]      = in_if[g].ready;
  end
  assign out_if.ready = out_rdy;

  hs_intf_arb_mux #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (in_if),
    .out_if    (out_if),
    .out_chan  (out_chan),
    .fifo_full (fifo_full)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    in_vld  = '0;
    out_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) in_dat[i] = '0;
    #2;
    n_vec++;
    if (in_rdy !== 4'b0000 || out_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: rdy=%b valid=%b, want rdy=0000 valid=0", in_rdy, out_if.valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_rdy !== 4'b1111 || out_if.valid !== 1'b0 || fifo_full !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_release: rdy=%b valid=%b full=%b, want 1111/0/0000", in_rdy, out_if.valid, fifo_full);
    end
    // Mid-stream: ch3 fills its FIFO behind a stalled output word.
    out_rdy   = 1'b0;
    in_vld[3] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_dat[3] = 8'hC0 + 8'(c);
      @(negedge clk);
    end
    in_vld[3] = 1'b0;
    n_vec++;
    if (out_if.valid !== 1'b1 || out_chan !== 2'd3 || fifo_full[3] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre: valid=%b chan=%0d full=%b, want 1/3/1xxx", out_if.valid, out_chan, fifo_full);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_if.valid !== 1'b0 || out_chan !== 2'd0 || fifo_full !== 4'b0000 ||
        in_rdy !== 4'b0000 || out_if.data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async: valid=%b chan=%0d full=%b rdy=%b data=%h, want all 0",
               out_if.valid, out_chan, fifo_full, in_rdy, out_if.data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_rdy !== 4'b1111 || out_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_after: rdy=%b valid=%b, want 1111/0", in_rdy, out_if.valid);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_stale: valid=%b, want 0", out_if.valid);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    do_reset();
    out_rdy   = 1'b1;
    in_vld[2] = 1'b1;
    in_dat[2] = exp[0];
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_lat0: valid=%b, want 0", out_if.valid);
    end
    for (int j = 0; j < 3; j++) begin
      if (j < 2) in_dat[2] = exp[j+1];
      else       in_vld[2] = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_if.valid !== 1'b1 || out_if.data !== exp[j] || out_chan !== 2'd2) begin
        n_err++;
        $display("FAIL single_word%0d: valid=%b data=%h chan=%0d, want 1/%h/2",
                 j, out_if.valid, out_if.data, out_chan, exp[j]);
      end
    end
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain: valid=%b, want 0", out_if.valid);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] ed;
    do_reset();
    in_vld = 4'b1111;
    for (int i = 0; i < N; i++) in_dat[i] = 8'hA0 + 8'(i);
    @(negedge clk);
    for (int i = 0; i < N; i++) in_dat[i] = 8'hB0 + 8'(i);
    @(negedge clk);
    in_vld  = '0;
    out_rdy = 1'b1;
    for (int j = 0; j < 8; j++) begin
      ed = (j < 4) ? 8'hA0 + 8'(j) : 8'hB0 + 8'(j - 4);
      n_vec++;
      if (out_if.valid !== 1'b1 || out_if.data !== ed || out_chan !== 2'(j % 4)) begin
        n_err++;
        $display("FAIL fair_%0d: valid=%b data=%h chan=%0d, want 1/%h/%0d",
                 j, out_if.valid, out_if.data, out_chan, ed, j % 4);
      end
      @(negedge clk);
    end
    n_vec++;
    if (out_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL fair_end: valid=%b, want 0", out_if.valid);
    end
  endtask

  task automatic test_backpressure();
    int  acc;
    logic r;
    do_reset();
    in_vld[0] = 1'b1;
    in_dat[0] = 8'h5A;
    @(negedge clk);
    in_vld[0] = 1'b0;
    @(negedge clk);
    acc = 0;
    in_vld[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_dat[0] = 8'h60 + 8'(acc);
      r = in_rdy[0];
      @(negedge clk);
      if (r) acc++;
      n_vec++;
      if (out_if.valid !== 1'b1 || out_if.data !== 8'h5A || out_chan !== 2'd0) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b data=%h chan=%0d, want 1/5a/0",
                 c, out_if.valid, out_if.data, out_chan);
      end
    end
    in_vld[0] = 1'b0;
    n_vec++;
    if (acc != DEPTH || fifo_full[0] !== 1'b1 || in_rdy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full: accepted=%0d full0=%b rdy0=%b, want %0d/1/0", acc, fifo_full[0], in_rdy[0], DEPTH);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_if.data !== 8'h60 || fifo_full[0] !== 1'b0 || in_rdy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: data=%h full0=%b rdy0=%b, want 60/0/1", out_if.data, fifo_full[0], in_rdy[0]);
    end
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      n_vec++;
      if (out_if.valid !== 1'b1 || out_if.data !== 8'h60 + 8'(j)) begin
        n_err++;
        $display("FAIL bp_drain%0d: valid=%b data=%h, want 1/%h", j, out_if.valid, out_if.data, 8'h60 + 8'(j));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int   p, r, cyc;
    logic push_ok, pop_ok;
    logic [7:0] d;
    logic [1:0] ch;
    do_reset();
    p = 0; r = 0; cyc = 0;
    while (r < 3 * DEPTH && cyc < 400) begin
      in_vld[1] = (p < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
      in_dat[1] = 8'hD0 + 8'(p);
      out_rdy   = ($urandom_range(0, 1) == 1);
      push_ok   = in_vld[1] & in_rdy[1];
      pop_ok    = out_if.valid & out_rdy;
      d         = out_if.data;
      ch        = out_chan;
      @(negedge clk);
      cyc++;
      if (push_ok) p++;
      if (pop_ok) begin
        n_vec++;
        if (d !== 8'hD0 + 8'(r) || ch !== 2'd1) begin
          n_err++;
          $display("FAIL wrap_word%0d: data=%h chan=%0d, want %h/1", r, d, ch, 8'hD0 + 8'(r));
        end
        r++;
      end
    end
    in_vld[1] = 1'b0;
    out_rdy   = 1'b1;
    n_vec++;
    if (r != 3 * DEPTH) begin
      n_err++;
      $display("FAIL wrap_count: received=%0d, want %0d", r, 3 * DEPTH);
    end
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_dup: valid=%b, want 0", out_if.valid);
    end
  endtask

  task automatic test_skip_empty();
    do_reset();
    out_rdy   = 1'b1;
    in_vld[1] = 1'b1;
    in_dat[1] = 8'h01;
    @(negedge clk);
    in_vld[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_vld    = 4'b1010;
    in_dat[1] = 8'h71;
    in_dat[3] = 8'h73;
    @(negedge clk);
    in_vld = '0;
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b1 || out_if.data !== 8'h73 || out_chan !== 2'd3) begin
      n_err++;
      $display("FAIL skip_first: valid=%b data=%h chan=%0d, want 1/73/3", out_if.valid, out_if.data, out_chan);
    end
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b1 || out_if.data !== 8'h71 || out_chan !== 2'd1) begin
      n_err++;
      $display("FAIL skip_second: valid=%b data=%h chan=%0d, want 1/71/1", out_if.valid, out_if.data, out_chan);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_skip_empty();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
